// File: rtl/song_reader.sv
// Song sequencer: walks {song, index} through the song ROM, issues one note at a
// time to the note player, and reports end of song via a one-cycle pulse.
module song_reader #(
  parameter int INDEX_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               play,
  input  logic [1:0]         song,
  input  logic               note_done,
  input  logic [11:0]        rom_data,
  output logic [INDEX_W+1:0] rom_addr,
  output logic [5:0]         note,
  output logic [5:0]         duration,
  output logic               new_note,
  output logic               song_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_ROM, S_ISSUE, S_WAIT_NOTE, S_DONE
  } state_t;

  localparam logic [INDEX_W-1:0] LAST_IDX = '1;

  state_t               r_state, w_state_nxt;
  logic [INDEX_W-1:0]   r_index, w_index_nxt;
  logic [INDEX_W+1:0]   r_rom_addr;
  logic [5:0]           r_note, r_duration;
  logic                 r_new_note, r_song_done;
  logic [1:0]           r_song;
  logic                 w_load, w_song_done_nxt;

  // ROM word is valid during WAIT_ROM, so it is captured on the edge into ISSUE;
  // r_new_note then doubles as "ISSUE holds a real note, not the end marker".
  always_comb begin
    w_state_nxt = r_state;
    w_index_nxt = r_index;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE:      if (play) w_state_nxt = S_FETCH;
      S_FETCH:     w_state_nxt = play ? S_WAIT_ROM : S_IDLE;
      S_WAIT_ROM: begin
        if (!play) w_state_nxt = S_IDLE;
        else begin
          w_state_nxt = S_ISSUE;
          w_load      = (rom_data[5:0] != 6'd0);
        end
      end
      S_ISSUE: begin
        if (!play)           w_state_nxt = S_IDLE;
        else if (r_new_note) w_state_nxt = S_WAIT_NOTE;
        else                 w_state_nxt = S_DONE;
      end
      S_WAIT_NOTE: begin
        if (!play) w_state_nxt = S_IDLE;
        else if (note_done) begin
          if (r_index == LAST_IDX) w_state_nxt = S_DONE;
          else begin
            w_index_nxt = r_index + 1'b1;
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_DONE:      if (!play) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
    if (w_state_nxt == S_DONE) w_index_nxt = '0;
    // A new song selection restarts from the top, overriding everything but reset.
    if (song != r_song) begin
      w_state_nxt = S_IDLE;
      w_index_nxt = '0;
      w_load      = 1'b0;
    end
    w_song_done_nxt = (w_state_nxt == S_DONE) && (r_state != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_index     <= '0;
      r_rom_addr  <= '0;
      r_note      <= '0;
      r_duration  <= '0;
      r_new_note  <= 1'b0;
      r_song_done <= 1'b0;
      r_song      <= song;
    end else begin
      r_state     <= w_state_nxt;
      r_index     <= w_index_nxt;
      r_rom_addr  <= {song, w_index_nxt};
      if (w_load) begin
        r_note     <= rom_data[11:6];
        r_duration <= rom_data[5:0];
      end
      r_new_note  <= w_load;
      r_song_done <= w_song_done_nxt;
      r_song      <= song;
    end
  end

  assign rom_addr  = r_rom_addr;
  assign note      = r_note;
  assign duration  = r_duration;
  assign new_note  = r_new_note;
  assign song_done = r_song_done;

endmodule

// File: tb/tb_song_reader.sv
// Directed bench for song_reader: synchronous ROM model, pulse counters, and
// hand-computed expectations for playback, pause, song change and reset.
module tb_song_reader;

  logic        clk = 1'b0;
  logic        reset, play, note_done;
  logic [1:0]  song;
  logic [11:0] rom_data;
  logic [6:0]  rom_addr;
  logic [5:0]  note, duration;
  logic        new_note, song_done;

  logic [11:0] rom [0:127];
  int n_tests = 0;
  int n_fail  = 0;
  int nn_cnt  = 0;
  int sd_cnt  = 0;
  int both_cnt = 0;

  song_reader #(.INDEX_W(5)) dut (
    .clk(clk), .reset(reset), .play(play), .song(song), .note_done(note_done),
    .rom_data(rom_data), .rom_addr(rom_addr), .note(note), .duration(duration),
    .new_note(new_note), .song_done(song_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  always @(negedge clk) begin
    if (new_note)              nn_cnt   <= nn_cnt + 1;
    if (song_done)             sd_cnt   <= sd_cnt + 1;
    if (new_note && song_done) both_cnt <= both_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for new_note (bounded), check latency and the latched note/duration.
  task automatic issue_check(input string tag, input logic [11:0] word, input int lat);
    int c;
    c = 0;
    while (new_note !== 1'b1 && c < 10) begin
      tick();
      c++;
    end
    chk({tag, "_lat"}, c, lat);
    chk({tag, "_nn"}, new_note, 1'b1);
    chk({tag, "_note"}, note, word[11:6]);
    chk({tag, "_dur"}, duration, word[5:0]);
  endtask

  // From ISSUE: step into WAIT_NOTE and deliver a one-cycle note_done.
  task automatic finish_note();
    tick();
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
  endtask

  initial begin
    int nn0, sd0;
    for (int i = 0; i < 32; i++) begin
      rom[i]      = {6'(i + 1), 6'((i % 7) + 1)};
      rom[32 + i] = {6'(i + 2), 6'd9};
      rom[64 + i] = {6'(i + 20), 6'd3};
      rom[96 + i] = {6'(i + 10), 6'((i % 5) + 1)};
    end
    rom[32] = 12'h2C5;
    rom[33] = 12'h187;
    rom[34] = 12'h0C2;
    rom[35] = 12'h400;

    reset = 1'b1; play = 1'b0; note_done = 1'b0; song = 2'd1;
    tick(); tick();
    chk("rst_addr", rom_addr, 0);
    chk("rst_note", note, 0);
    chk("rst_dur", duration, 0);
    chk("rst_nn", new_note, 0);
    chk("rst_sd", song_done, 0);
    reset = 1'b0;
    tick();

    // First note of song 1, with exact cycle-by-cycle latency
    nn0 = nn_cnt; sd0 = sd_cnt;
    play = 1'b1;
    tick();
    chk("s1_fetch_addr", rom_addr, 32);
    chk("s1_fetch_nn", new_note, 0);
    tick();
    chk("s1_wrom_nn", new_note, 0);
    tick();
    chk("s1_issue_nn", new_note, 1);
    chk("s1_issue_note", note, 6'h0B);
    chk("s1_issue_dur", duration, 6'h05);

    // Remaining notes then the end marker at slot 3
    finish_note();
    chk("s1_fetch1_addr", rom_addr, 33);
    issue_check("s1_n1", rom[33], 2);
    finish_note();
    issue_check("s1_n2", rom[34], 2);
    finish_note();
    chk("s1_fetch3_addr", rom_addr, 35);
    tick(); tick();
    chk("s1_marker_nn", new_note, 0);
    tick();
    chk("s1_done_sd", song_done, 1);
    chk("s1_done_addr", rom_addr, 32);
    tick();
    chk("s1_done_sd_once", song_done, 0);
    tick(); tick();
    chk("s1_nn_count", nn_cnt - nn0, 3);
    chk("s1_sd_count", sd_cnt - sd0, 1);

    // Song 0: all 32 slots, song_done after the last note_done
    play = 1'b0; song = 2'd0;
    tick();
    nn0 = nn_cnt; sd0 = sd_cnt;
    play = 1'b1;
    for (int k = 0; k < 32; k++) begin
      issue_check($sformatf("s0_n%0d", k), rom[k], (k == 0) ? 3 : 2);
      if (k < 31) finish_note();
    end
    tick();
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
    chk("s0_done_sd", song_done, 1);
    chk("s0_done_addr", rom_addr, 0);
    tick(); tick(); tick();
    chk("s0_hold_sd", song_done, 0);
    chk("s0_nn_count", nn_cnt - nn0, 32);
    chk("s0_sd_count", sd_cnt - sd0, 1);
    play = 1'b0;
    tick();

    // Pause in WAIT_NOTE at index 4, resume 5 cycles later
    play = 1'b1;
    for (int k = 0; k < 4; k++) begin
      issue_check($sformatf("p_n%0d", k), rom[k], (k == 0) ? 3 : 2);
      finish_note();
    end
    issue_check("p_n4", rom[4], 2);
    tick();
    chk("p_wait_addr", rom_addr, 4);
    nn0 = nn_cnt; sd0 = sd_cnt;
    play = 1'b0;
    tick(); tick();
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
    tick(); tick();
    chk("p_pause_nn", nn_cnt - nn0, 0);
    chk("p_pause_sd", sd_cnt - sd0, 0);
    chk("p_pause_addr", rom_addr, 4);
    play = 1'b1;
    tick();
    chk("p_refetch_addr", rom_addr, 4);
    issue_check("p_reissue", rom[4], 2);

    // Song 2 -> 3 change in WAIT_NOTE at index 7
    play = 1'b0;
    tick();
    song = 2'd2;
    tick();
    chk("s2_idle_addr", rom_addr, 64);
    play = 1'b1;
    for (int k = 0; k < 7; k++) begin
      issue_check($sformatf("s2_n%0d", k), rom[64 + k], (k == 0) ? 3 : 2);
      finish_note();
    end
    issue_check("s2_n7", rom[71], 2);
    tick();
    chk("s2_wait_addr", rom_addr, 71);
    song = 2'd3;
    tick();
    chk("chg_addr", rom_addr, 96);
    chk("chg_nn", new_note, 0);
    tick();
    chk("chg_fetch_addr", rom_addr, 96);
    issue_check("s3_n0", rom[96], 2);

    // Reset with note_done in WAIT_NOTE at index 9
    finish_note();
    for (int k = 1; k < 9; k++) begin
      issue_check($sformatf("s3_n%0d", k), rom[96 + k], 2);
      finish_note();
    end
    issue_check("s3_n9", rom[105], 2);
    tick();
    chk("s3_wait_addr", rom_addr, 105);
    nn0 = nn_cnt; sd0 = sd_cnt;
    reset = 1'b1; note_done = 1'b1;
    tick();
    chk("mrst_addr", rom_addr, 0);
    chk("mrst_note", note, 0);
    chk("mrst_dur", duration, 0);
    chk("mrst_nn", new_note, 0);
    chk("mrst_sd", song_done, 0);
    reset = 1'b0; note_done = 1'b0;
    tick();
    chk("mrst_fetch_addr", rom_addr, 96);
    chk("mrst_sd_count", sd_cnt - sd0, 0);
    chk("mrst_nn_count", nn_cnt - nn0, 0);
    issue_check("mrst_refetch", rom[96], 2);

    chk("never_both", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
